// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM-port arbiter: owner tags, size codes, bus widths.
package sram_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned SIZE_W_BITS = 2;

   // Owner tag stored per outstanding request
   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   // SRAM transfer size codes
   localparam logic [SIZE_W_BITS-1:0] SIZE_B = 2'd0;
   localparam logic [SIZE_W_BITS-1:0] SIZE_H = 2'd1;
   localparam logic [SIZE_W_BITS-1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_arbiter_if.sv
// CPU-side masters plus the merged memory port; slave = arbiter view, master = environment view.
interface sram_arbiter_if
   import sram_arbiter_pkg::*;
();
   logic                   inst_req;
   logic [ADDR_W-1:0]      inst_addr;
   logic                   inst_addr_ok;
   logic                   inst_data_ok;
   logic [DATA_W-1:0]      inst_rdata;

   logic                   data_req;
   logic                   data_wr;
   logic [SIZE_W_BITS-1:0] data_size;
   logic [STRB_W-1:0]      data_wstrb;
   logic [ADDR_W-1:0]      data_addr;
   logic [DATA_W-1:0]      data_wdata;
   logic                   data_addr_ok;
   logic                   data_data_ok;
   logic [DATA_W-1:0]      data_rdata;

   logic                   mem_req;
   logic                   mem_wr;
   logic [SIZE_W_BITS-1:0] mem_size;
   logic [STRB_W-1:0]      mem_wstrb;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic                   mem_addr_ok;
   logic                   mem_data_ok;
   logic [DATA_W-1:0]      mem_rdata;

   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata
   );

   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata
   );

endinterface

// File: rtl/sram_arbiter_tag_fifo.sv
// In-order 1-bit owner-tag FIFO; push is refused when full, pop is ignored when empty.
module tag_fifo #(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic clk,
   input  logic resetn,
   input  logic push_i,
   input  logic pop_i,
   input  logic tag_i,
   output logic head_o,
   output logic full_o,
   output logic empty_o
);

   logic [DEPTH-1:0] tags_q,   tags_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             push_ok, pop_ok;

   // Status flags come straight from the occupancy count
   always_comb begin
      full_o  = (count_q == CNT_W'(DEPTH));
      empty_o = (count_q == '0);
      head_o  = tags_q[rd_ptr_q];
      push_ok = push_i & ~full_o;
      pop_ok  = pop_i & ~empty_o;
   end

   // Next-state: pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      tags_d   = tags_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         tags_d[wr_ptr_q] = tag_i;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tags_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         tags_q   <= tags_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Merges the IF and MEM masters onto one SRAM-like port and steers in-order responses back.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic          clk,
   input  logic          resetn,
   sram_arbiter_if.slave bus
);

   logic lock_valid_q, lock_valid_d;
   logic lock_owner_q, lock_owner_d;
   logic grant_owner, owner_req, mem_req, accept, resp;
   logic fifo_full, fifo_empty, fifo_head;

   tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (accept),
      .pop_i   (bus.mem_data_ok),
      .tag_i   (grant_owner),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Grant: a stalled handshake keeps its owner, otherwise data beats inst
   always_comb begin
      grant_owner = lock_valid_q ? lock_owner_q
                                 : (bus.data_req ? OWNER_DATA : OWNER_INST);
      owner_req   = (grant_owner == OWNER_DATA) ? bus.data_req : bus.inst_req;
      mem_req     = owner_req & ~fifo_full;
      accept      = mem_req & bus.mem_addr_ok;
      resp        = bus.mem_data_ok & ~fifo_empty;
   end

   // Memory-port muxing and response steering; idle port drives all zeros
   always_comb begin
      bus.mem_req   = mem_req;
      bus.mem_wr    = 1'b0;
      bus.mem_size  = '0;
      bus.mem_wstrb = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (mem_req) begin
         if (grant_owner == OWNER_DATA) begin
            bus.mem_wr    = bus.data_wr;
            bus.mem_size  = bus.data_size;
            bus.mem_wstrb = bus.data_wstrb;
            bus.mem_addr  = bus.data_addr;
            bus.mem_wdata = bus.data_wdata;
         end else begin
            bus.mem_size  = SIZE_W;
            bus.mem_addr  = bus.inst_addr;
         end
      end
      bus.inst_addr_ok = accept & (grant_owner == OWNER_INST);
      bus.data_addr_ok = accept & (grant_owner == OWNER_DATA);
      bus.inst_data_ok = resp & (fifo_head == OWNER_INST);
      bus.data_data_ok = resp & (fifo_head == OWNER_DATA);
      bus.inst_rdata   = bus.mem_rdata;
      bus.data_rdata   = bus.mem_rdata;
   end

   // Lock holds while the slave has seen req but not accepted; any other cycle releases it
   always_comb begin
      lock_valid_d = mem_req & ~bus.mem_addr_ok;
      lock_owner_d = lock_valid_d ? grant_owner : lock_owner_q;
   end

   // Lock registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_valid_q <= 1'b0;
         lock_owner_q <= OWNER_INST;
      end else begin
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
      end
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master (read-only) and the data master driven by the MEM stage.
- Arbitrates address-phase requests and records the owner of every accepted request in an in-order tag FIFO.
- Steers each returning data_ok/rdata back to the owner of the oldest outstanding request.
- Sits between the IF/EX/MEM stages and the top-level memory bridge.

Parameters:
MAX_OUTST, 4, max accepted-but-unanswered requests; power of two, ≥2
PTR_W, $clog2(MAX_OUTST), FIFO pointer width (derived, not overridden)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  IF request
inst_addr  in  32  IF address
inst_addr_ok  out  1  IF request accepted
inst_data_ok  out  1  IF read data valid
inst_rdata  out  32  IF read data
data_req  in  1  data request
data_wr  in  1  1 = store
data_size  in  2  0 byte, 1 half, 2 word
data_wstrb  in  4  byte strobes
data_addr  in  32  data address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  load data valid / store done
data_rdata  out  32  load data
mem_req  out  1  merged request
mem_wr  out  1  merged write flag
mem_size  out  2  merged size
mem_wstrb  out  4  merged strobes
mem_addr  out  32  merged address
mem_wdata  out  32  merged write data
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response, strictly in order
mem_rdata  in  32  slave read data

Behaviour:
- Registers: lock_valid, lock_owner, tag FIFO (MAX_OUTST × 1 bit, 0 = inst, 1 = data), rd_ptr, wr_ptr, count (PTR_W+1 bits). All clear asynchronously on resetn low.
- After reset, all outputs are 0. All outputs are combinational from registers and inputs.
- Grant:
  - If lock_valid, grant = lock_owner.
  - Otherwise data_req wins over inst_req (fixed priority; the data side is older in program order).
  - No request, or count == MAX_OUTST (full): no grant, mem_req = 0, both addr_ok = 0.
- Inst request fields on the mem port: mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0.
- Data request fields pass through unchanged.
- mem_req = granted master's req & !full.
- granted master's addr_ok = mem_addr_ok & mem_req; the other master's addr_ok = 0.
- Lock:
  - When mem_req = 1 and mem_addr_ok = 0, set lock_valid = 1 and lock_owner = grant. The grant must not switch while the slave may have sampled req.
  - Clear the lock on the cycle mem_req & mem_addr_ok.
  - If the locked master drops req while locked, the lock clears next cycle (protocol violation tolerated).
- Push: on mem_req & mem_addr_ok, write the owner tag at wr_ptr and advance wr_ptr. The pointer wraps modulo MAX_OUTST.
- Pop: on mem_data_ok & count != 0:
  - Route to the head tag: inst_data_ok or data_data_ok = 1.
  - Advance rd_ptr.
  - Both rdata outputs = mem_rdata unconditionally.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A full FIFO blocks new pushes in that cycle, even if a pop also occurs. The freed slot is usable next cycle.
- mem_data_ok with count == 0: ignored; both data_ok = 0; no state change.
- Latency:
  - Address phase: zero added cycles (combinational pass).
  - Response: zero added cycles.
  - Throughput: one request per cycle while not full.
- Reset mid-operation clears all outstanding tags. Responses still in flight in the slave are then dropped by the empty rule.

Decomposition:
- Shared package: owner tag constants OWNER_INST = 1'b0 and OWNER_DATA = 1'b1, and SRAM size codes SIZE_B/H/W.
- One natural sub-module: tag_fifo (1-bit-wide synchronous FIFO, parameterised depth, push/pop/full/empty/head). The arbiter wraps it with grant and lock logic.

Test Plan:
- Single inst read: inst_req=1, addr 0x1C000000; slave addr_ok same cycle, data_ok 2 cycles later with 0xDEADBEEF -> inst_addr_ok=1 at cycle 0, inst_data_ok=1 with inst_rdata=0xDEADBEEF at cycle 2, data_data_ok stays 0.
- Simultaneous requests: inst_req and data_req (store, wstrb 0xF, addr 0x100) both asserted -> data granted first, mem_wr=1. Inst granted next cycle. Responses in order: data_data_ok, then inst_data_ok.
- Lock: data_req at cycle 0 with mem_addr_ok=0 for 3 cycles; inst_req asserted at cycle 1 -> mem_addr stays data_addr until accepted at cycle 3; inst accepted at cycle 4.
- Full: MAX_OUTST=4, four inst requests accepted with no responses -> fifth held (mem_req=0, inst_addr_ok=0). One mem_data_ok pops; fifth accepted the following cycle.
- Spurious response: mem_data_ok=1 with an empty FIFO -> both data_ok 0, count stays 0.
- Reset mid-flight: two requests outstanding, resetn pulled low asynchronously mid-cycle -> count=0 immediately, all outputs 0; later mem_data_ok ignored.
